selecter_demux: RTL and testbench
=================================

Name: selecter_demux

Overview:
- Registered 1-to-3 distributor: the inverse of the team's 3:1 selecter.
- Takes one W-bit word plus a 2-bit route code (SW), and delivers the word to one of three output channels A/B/C.
- Each channel has a one-entry holding register with a valid/ready handshake.
- Route code 00 is the "no destination" code: the word is consumed and counted as dropped.

Parameters:
- W, 3, data width of input and each output channel.
- CW, 8, width of the saturating drop counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- I  input  W  input data word.
- SW  input  2  route code: 00 = drop, 01 = A, 10 = B, 11 = C.
- EN  input  1  input valid, qualifies I and SW.
- RDY  output  1  input ready (combinational).
- OA  output  W  channel A data (registered).
- VA  output  1  channel A valid (registered).
- RA  input  1  channel A consumer ready.
- OB  output  W  channel B data (registered).
- VB  output  1  channel B valid (registered).
- RB  input  1  channel B consumer ready.
- OC  output  W  channel C data (registered).
- VC  output  1  channel C valid (registered).
- RC  input  1  channel C consumer ready.
- DROP  output  CW  count of words accepted with SW=00 (registered, saturating).

Behaviour:
- Reset, sampled on the CLK rising edge while RST=1: VA=VB=VC=0, OA=OB=OC=0, DROP=0. RST has priority over all other activity.
- Reset mid-operation discards any pending words. No handshake completes in a reset cycle.
- Input transfer occurs on a rising edge where EN=1 and RDY=1.
- RDY depends only on the current SW and the state of the selected channel:
  - SW=00: RDY=1.
  - SW=01: RDY = !VA | RA.
  - SW=10: RDY = !VB | RB.
  - SW=11: RDY = !VC | RC.
- RDY depends only on SW, the Vx registers and the Rx inputs. It does not depend on EN, so there is no combinational loop through EN.
- Output transfer on channel x occurs on an edge where Vx=1 and Rx=1.
- Channel x register update, per edge:
  - Load (input transfer routed to x): Ox<=I, Vx<=1. This applies even if the channel drains in the same cycle. Drain plus load gives back-to-back throughput of 1 word per cycle per channel.
  - Drain only: Vx<=0. Ox holds its last value (not cleared).
  - Neither: Ox and Vx hold.
- While Vx=1 and Rx=0, Ox and Vx are stable. A consumer stall never corrupts data.
- Latency: a word accepted on edge n is visible on Ox with Vx=1 after edge n, i.e. one cycle.
- Channels are independent: a stall on one channel never blocks words routed to another.
- Drop path: an input transfer with SW=00 changes no channel and increments DROP by 1. DROP saturates at 2^CW-1 and does not wrap.
- Ordering: words to the same channel are delivered in acceptance order. No ordering is guaranteed across channels.
- EN=1 with RDY=0: nothing is consumed. The producer must hold I and SW stable until transfer.
- X on SW while EN=0 has no effect on state.

Test Plan:
- Reset: assert RST for 2 cycles with EN=1, SW=01, I=5 -> VA=VB=VC=0, OA=OB=OC=0, DROP=0, with no load during reset.
- Basic routing: RA=RB=RC=1; send I=3/SW=01, I=6/SW=10, I=7/SW=11 on consecutive cycles -> each Vx pulses high for one cycle, one cycle after its accept, with OA=3, OB=6, OC=7.
- Backpressure: RB=0; send I=2/SW=10 -> VB=1, OB=2. Then present I=4/SW=10 -> RDY=0 and OB holds 2. Raise RB -> the same edge drains 2 and loads 4, VB stays 1, then OB=4.
- Channel independence: with VB stuck (RB=0) and the B register full, send I=1/SW=01 -> RDY=1 and OA=1 next cycle, while OB stays unchanged.
- Drop and saturation: with CW=8, send 300 words with SW=00 -> RDY=1 throughout, no Vx asserts, and DROP=255 at the end, not 44.
- Reset mid-operation: VA=VC=1 with RA=RC=0; pulse RST for one cycle -> VA=VC=0, outputs 0, DROP=0. A following I=5/SW=11 gives OC=5 with VC=1 one cycle later.

Source files
------------

// File: rtl/selecter_demux.sv
// Registered 1-to-3 distributor. One input word plus a 2-bit route code goes
// to channel A, B or C, or is dropped. Each channel keeps one word in a
// holding register with a valid/ready handshake.
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous reset, active-high, priority over everything
//   I, SW, EN    input word, route code (00 drop, 01 A, 10 B, 11 C), valid
//   RDY          input ready (combinational from SW, Vx, Rx)
//   OA/VA/RA     channel A data, valid (registered), consumer ready
//   OB/VB/RB     channel B data, valid (registered), consumer ready
//   OC/VC/RC     channel C data, valid (registered), consumer ready
//   DROP         saturating count of words accepted with SW=00 (registered)
module selecter_demux #(
  parameter int unsigned W  = 3,
  parameter int unsigned CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [W-1:0]  I,
  input  logic [1:0]    SW,
  input  logic          EN,
  output logic          RDY,
  output logic [W-1:0]  OA,
  output logic          VA,
  input  logic          RA,
  output logic [W-1:0]  OB,
  output logic          VB,
  input  logic          RB,
  output logic [W-1:0]  OC,
  output logic          VC,
  input  logic          RC,
  output logic [CW-1:0] DROP
);

  localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};

  logic accept;
  logic load_a;
  logic load_b;
  logic load_c;
  logic load_drop;

  // Ready looks only at the selected channel so EN never feeds back into RDY.
  always_comb begin
    RDY = 1'b1;
    case (SW)
      2'b00:   RDY = 1'b1;
      2'b01:   RDY = !VA || RA;
      2'b10:   RDY = !VB || RB;
      2'b11:   RDY = !VC || RC;
      default: RDY = 1'b1;
    endcase
  end

  // Input transfer decode; EN gates everything so an unknown SW is harmless.
  always_comb begin
    accept    = EN && RDY;
    load_drop = accept && (SW == 2'b00);
    load_a    = accept && (SW == 2'b01);
    load_b    = accept && (SW == 2'b10);
    load_c    = accept && (SW == 2'b11);
  end

  // Channel A holding register: load wins over drain for back-to-back flow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OA <= '0;
      VA <= 1'b0;
    end else if (load_a) begin
      OA <= I;
      VA <= 1'b1;
    end else if (VA && RA) begin
      VA <= 1'b0;
    end
  end

  // Channel B holding register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OB <= '0;
      VB <= 1'b0;
    end else if (load_b) begin
      OB <= I;
      VB <= 1'b1;
    end else if (VB && RB) begin
      VB <= 1'b0;
    end
  end

  // Channel C holding register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OC <= '0;
      VC <= 1'b0;
    end else if (load_c) begin
      OC <= I;
      VC <= 1'b1;
    end else if (VC && RC) begin
      VC <= 1'b0;
    end
  end

  // Saturating drop counter: sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DROP <= '0;
    end else if (load_drop && (DROP != DROP_MAX)) begin
      DROP <= DROP + CW'(1);
    end
  end

endmodule

// File: tb/tb_selecter_demux.sv
// Directed bench for selecter_demux with a per-channel scoreboard: accepted
// words are queued at the accepting edge and compared when the channel drains.
module tb_selecter_demux;

  localparam int unsigned W  = 3;
  localparam int unsigned CW = 8;

  logic          CLK;
  logic          RST;
  logic [W-1:0]  I;
  logic [1:0]    SW;
  logic          EN;
  logic          RDY;
  logic [W-1:0]  OA, OB, OC;
  logic          VA, VB, VC;
  logic          RA, RB, RC;
  logic [CW-1:0] DROP;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  q [3][$];
  logic [CW-1:0] drop_m;
  bit            model_ok = 0;

  selecter_demux #(.W(W), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .I(I), .SW(SW), .EN(EN), .RDY(RDY),
    .OA(OA), .VA(VA), .RA(RA),
    .OB(OB), .VB(VB), .RB(RB),
    .OC(OC), .VC(VC), .RC(RC),
    .DROP(DROP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs driven: checks state against the
  // model, records the handshakes of the coming rising edge, then advances.
  task automatic tick();
    logic [2:0]   v;
    logic [2:0]   r;
    logic [W-1:0] o [3];
    logic [W-1:0] front;
    logic         rdy_e;
    int           sel;
    #1;
    v = {VC, VB, VA};
    r = {RC, RB, RA};
    o[0] = OA; o[1] = OB; o[2] = OC;
    if (RST === 1'b1) begin
      @(posedge CLK);
      for (int c = 0; c < 3; c++) q[c].delete();
      drop_m   = '0;
      model_ok = 1;
    end else begin
      if (model_ok) begin
        for (int c = 0; c < 3; c++) begin
          check($sformatf("valid_ch%0d", c), 32'(v[c]), 32'(q[c].size() != 0));
          if ((q[c].size() != 0) && r[c]) begin
            front = q[c].pop_front();
            check($sformatf("data_ch%0d", c), 32'(o[c]), 32'(front));
          end
        end
        check("drop_count", 32'(DROP), 32'(drop_m));
        if (!$isunknown(SW)) begin
          sel = int'(SW) - 1;
          rdy_e = (SW == 2'b00) ? 1'b1 : ((q[sel].size() == 0) || r[sel]);
          // q was already popped on drain, so recompute against pre-edge state
          if (SW != 2'b00) rdy_e = !v[sel] || r[sel];
          check("rdy", 32'(RDY), 32'(rdy_e));
          if (EN === 1'b1 && rdy_e) begin
            if (SW == 2'b00) begin
              if (drop_m != {CW{1'b1}}) drop_m = drop_m + CW'(1);
            end else begin
              q[sel].push_back(I);
            end
          end
        end
      end
      @(posedge CLK);
    end
    @(negedge CLK);
  endtask

  initial begin
    // Reset with a live load request that must be ignored.
    RST = 1'b1; EN = 1'b1; SW = 2'b01; I = 3'd5;
    RA = 1'b1; RB = 1'b1; RC = 1'b1;
    @(negedge CLK);
    tick();
    tick();
    RST = 1'b0; EN = 1'b0;
    #1;
    check("rst_va", 32'(VA), 32'd0);
    check("rst_vb", 32'(VB), 32'd0);
    check("rst_vc", 32'(VC), 32'd0);
    check("rst_oa", 32'(OA), 32'd0);
    check("rst_ob", 32'(OB), 32'd0);
    check("rst_oc", 32'(OC), 32'd0);
    check("rst_drop", 32'(DROP), 32'd0);

    // Basic routing, one word per channel on consecutive cycles.
    EN = 1'b1; I = 3'd3; SW = 2'b01; tick();
    check("route_va", 32'(VA), 32'd1);
    check("route_oa", 32'(OA), 32'd3);
    I = 3'd6; SW = 2'b10; tick();
    check("route_ob", 32'(OB), 32'd6);
    check("route_va_pulse", 32'(VA), 32'd0);
    I = 3'd7; SW = 2'b11; tick();
    check("route_oc", 32'(OC), 32'd7);
    check("route_vb_pulse", 32'(VB), 32'd0);
    EN = 1'b0; tick();
    check("route_vc_pulse", 32'(VC), 32'd0);

    // Backpressure on B, then simultaneous drain and load.
    RB = 1'b0; EN = 1'b1; I = 3'd2; SW = 2'b10; tick();
    check("bp_vb", 32'(VB), 32'd1);
    check("bp_ob", 32'(OB), 32'd2);
    I = 3'd4;
    #1;
    check("bp_rdy_low", 32'(RDY), 32'd0);
    tick();
    check("bp_ob_hold", 32'(OB), 32'd2);
    RB = 1'b1; tick();
    check("bp_vb_stay", 32'(VB), 32'd1);
    check("bp_ob_new", 32'(OB), 32'd4);
    EN = 1'b0; tick();

    // Stalled B must not block A.
    RB = 1'b0; EN = 1'b1; I = 3'd5; SW = 2'b10; tick();
    I = 3'd1; SW = 2'b01;
    #1;
    check("ind_rdy", 32'(RDY), 32'd1);
    tick();
    check("ind_oa", 32'(OA), 32'd1);
    check("ind_ob", 32'(OB), 32'd5);
    check("ind_vb", 32'(VB), 32'd1);
    EN = 1'b0; SW = 2'bxx; tick();
    RB = 1'b1; tick();
    tick();

    // Drop path with saturation.
    EN = 1'b1; SW = 2'b00; I = 3'd0;
    for (int n = 0; n < 300; n++) tick();
    EN = 1'b0;
    check("drop_sat", 32'(DROP), 32'd255);
    tick();

    // Reset in the middle of stalled traffic.
    RA = 1'b0; RC = 1'b0; EN = 1'b1;
    I = 3'd2; SW = 2'b01; tick();
    I = 3'd3; SW = 2'b11; tick();
    EN = 1'b0;
    check("mid_va", 32'(VA), 32'd1);
    check("mid_vc", 32'(VC), 32'd1);
    RST = 1'b1; tick();
    RST = 1'b0;
    check("mid_rst_va", 32'(VA), 32'd0);
    check("mid_rst_vc", 32'(VC), 32'd0);
    check("mid_rst_oa", 32'(OA), 32'd0);
    check("mid_rst_ob", 32'(OB), 32'd0);
    check("mid_rst_oc", 32'(OC), 32'd0);
    check("mid_rst_drop", 32'(DROP), 32'd0);
    RA = 1'b1; RC = 1'b1;
    EN = 1'b1; I = 3'd5; SW = 2'b11; tick();
    EN = 1'b0;
    check("post_vc", 32'(VC), 32'd1);
    check("post_oc", 32'(OC), 32'd5);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
